// File: rtl/hovalaag_pkg.sv
// Shared definitions for the flow-controlled Hovalaag core.
// Contents:
//   - instruction field bit positions;
//   - per-unit operation encodings;
//   - ALU opcode encodings;
//   - K/L constant extension helpers.
// The helpers return EXT_W bits. Callers narrow the result to their own
// width with a size cast, so any DATA_W/PC_W up to EXT_W is supported.
package hovalaag_pkg;

    localparam int EXT_W = 64;

    // Instruction field positions
    localparam int ALU_LSB = 28;
    localparam int A_LSB   = 26;
    localparam int B_LSB   = 24;
    localparam int C_LSB   = 22;
    localparam int D_BIT   = 21;
    localparam int W_LSB   = 19;
    localparam int F_LSB   = 17;
    localparam int PC_LSB  = 15;
    localparam int O_BIT   = 14;
    localparam int IO_BIT  = 13;
    localparam int LK_BIT  = 12;

    // Unit operation encodings
    localparam logic [1:0] A_HOLD   = 2'b00, A_M    = 2'b01, A_D     = 2'b10, A_IN     = 2'b11;
    localparam logic [1:0] B_HOLD   = 2'b00, B_M    = 2'b01, B_A     = 2'b10, B_K      = 2'b11;
    localparam logic [1:0] C_HOLD   = 2'b00, C_M    = 2'b01, C_DEC   = 2'b10, C_DECNZ  = 2'b11;
    localparam logic [1:0] W_HOLD   = 2'b00, W_M    = 2'b01, W_A     = 2'b10, W_K      = 2'b11;
    localparam logic [1:0] F_HOLD   = 2'b00, F_ZERO = 2'b01, F_NEWF  = 2'b10, F_NOTF   = 2'b11;
    localparam logic [1:0] PC_INC   = 2'b00, PC_JMP = 2'b01, PC_JF   = 2'b10, PC_JNF   = 2'b11;

    // ALU opcodes
    localparam logic [3:0] ALU_A    = 4'd0,  ALU_B    = 4'd1,  ALU_NOTA = 4'd2,  ALU_NOTB = 4'd3;
    localparam logic [3:0] ALU_ADD  = 4'd4,  ALU_SUB  = 4'd5,  ALU_ADC  = 4'd6,  ALU_SBC  = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8,  ALU_OR   = 4'd9,  ALU_XOR  = 4'd10, ALU_SHL  = 4'd11;
    localparam logic [3:0] ALU_SHR  = 4'd12, ALU_C    = 4'd13, ALU_RSUB = 4'd14, ALU_ZERO = 4'd15;

    // K constant: 12-bit long form or 6-bit short form, sign-extended
    function automatic logic [EXT_W-1:0] k_ext(input logic [31:0] ins);
        logic [EXT_W-1:0] r;
        if (ins[LK_BIT]) r = {{(EXT_W-12){ins[11]}}, ins[11:0]};
        else             r = {{(EXT_W-6){ins[11]}}, ins[11:6]};
        return r;
    endfunction

    // L constant: 8-bit long form or 6-bit short form, zero-extended
    function automatic logic [EXT_W-1:0] l_ext(input logic [31:0] ins);
        logic [EXT_W-1:0] r;
        if (ins[LK_BIT]) r = {{(EXT_W-8){1'b0}}, ins[7:0]};
        else             r = {{(EXT_W-6){1'b0}}, ins[5:0]};
        return r;
    endfunction

endpackage

// File: rtl/hovalaag_stall_core_if.sv
// Handshake and fetch bundle for hovalaag_stall_core.
// Signal groups:
//   - in1/in2: valid/ready input channels;
//   - out:     valid/ready output channel with a channel select;
//   - fetch:   instr in, pc out;
//   - status:  stall.
// Modports:
//   - master: the core's view;
//   - slave:  the environment's view.
interface hovalaag_stall_core_if #(
    parameter int DATA_W = 12,
    parameter int PC_W   = 8
) ();
    logic [DATA_W-1:0] in1_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] in2_data;
    logic              in2_valid;
    logic              in2_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_select;
    logic              out_ready;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
    logic              stall;

    modport master (
        input  in1_data, in1_valid, in2_data, in2_valid, out_ready, instr,
        output in1_ready, in2_ready, out_data, out_valid, out_select, pc, stall
    );

    modport slave (
        output in1_data, in1_valid, in2_data, in2_valid, out_ready, instr,
        input  in1_ready, in2_ready, out_data, out_valid, out_select, pc, stall
    );
endinterface

// File: rtl/hovalaag_alu.sv
// Hovalaag 16-operation ALU. Purely combinational.
// Ports:
//   - op:     ALU opcode;
//   - a/b/c:  operands;
//   - f:      carry/borrow input;
//   - m:      result;
//   - new_f:  carry/borrow/shift-out flag.
// Logic operations produce new_f = 0.
module hovalaag_alu
    import hovalaag_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic              f,
    output logic [DATA_W-1:0] m,
    output logic              new_f
);
    logic [DATA_W:0] wide_s;

    // Operation select. For arithmetic ops, the extra top bit of wide_s is
    // the carry, or the borrow for subtractions.
    always_comb begin
        wide_s = '0;
        m      = '0;
        new_f  = 1'b0;
        case (op)
            ALU_A:    m = a;
            ALU_B:    m = b;
            ALU_NOTA: m = ~a;
            ALU_NOTB: m = ~b;
            ALU_ADD:  begin wide_s = {1'b0, a} + {1'b0, b};                          m = wide_s[DATA_W-1:0]; new_f = wide_s[DATA_W]; end
            ALU_SUB:  begin wide_s = {1'b0, a} - {1'b0, b};                          m = wide_s[DATA_W-1:0]; new_f = wide_s[DATA_W]; end
            ALU_ADC:  begin wide_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, f};    m = wide_s[DATA_W-1:0]; new_f = wide_s[DATA_W]; end
            ALU_SBC:  begin wide_s = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, f};    m = wide_s[DATA_W-1:0]; new_f = wide_s[DATA_W]; end
            ALU_AND:  m = a & b;
            ALU_OR:   m = a | b;
            ALU_XOR:  m = a ^ b;
            ALU_SHL:  begin m = {a[DATA_W-2:0], 1'b0}; new_f = a[DATA_W-1]; end
            ALU_SHR:  begin m = {1'b0, a[DATA_W-1:1]}; new_f = a[0]; end
            ALU_C:    m = c;
            ALU_RSUB: begin wide_s = {1'b0, b} - {1'b0, a};                          m = wide_s[DATA_W-1:0]; new_f = wide_s[DATA_W]; end
            ALU_ZERO: m = '0;
            default:  m = '0;
        endcase
    end
endmodule

// File: rtl/hovalaag_stall_core.sv
// Flow-controlled Hovalaag CPU core.
// Execution:
//   - one instruction per cycle;
//   - an instruction commits only when its IN read and OUT write can both
//     complete;
//   - otherwise stall is raised and all architectural state holds.
// Ports:
//   - clk, rst: clock and asynchronous active-high reset;
//   - bus:      hovalaag_stall_core_if master (in1/in2, out, instr/pc, stall).
module hovalaag_stall_core
    import hovalaag_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int PC_W   = 8
) (
    input  logic clk,
    input  logic rst,
    hovalaag_stall_core_if.master bus
);
    logic [3:0]        alu_op_s;
    logic [1:0]        a_op_s, b_op_s, c_op_s, w_op_s, f_op_s, pc_op_s;
    logic              d_op_s, o_s, io_s;
    logic [DATA_W-1:0] k_s, in_data_s, alu_m_s, c_dec_s;
    logic [PC_W-1:0]   l_s, pc_inc_s;
    logic              alu_new_f_s, sel_valid_s, in_blocked_s, out_blocked_s, commit_s;
    logic [DATA_W-1:0] a_r, b_r, c_r, d_r, w_r, out_data_r;
    logic              f_r, out_select_r, out_valid_r;
    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] a_nx_s, b_nx_s, c_nx_s, d_nx_s, w_nx_s;
    logic              f_nx_s;
    logic [PC_W-1:0]   pc_nx_s;

    assign alu_op_s = bus.instr[ALU_LSB +: 4];
    assign a_op_s   = bus.instr[A_LSB +: 2];
    assign b_op_s   = bus.instr[B_LSB +: 2];
    assign c_op_s   = bus.instr[C_LSB +: 2];
    assign d_op_s   = bus.instr[D_BIT];
    assign w_op_s   = bus.instr[W_LSB +: 2];
    assign f_op_s   = bus.instr[F_LSB +: 2];
    assign pc_op_s  = bus.instr[PC_LSB +: 2];
    assign o_s      = bus.instr[O_BIT];
    assign io_s     = bus.instr[IO_BIT];
    assign k_s      = DATA_W'(k_ext(bus.instr));
    assign l_s      = PC_W'(l_ext(bus.instr));

    assign sel_valid_s   = io_s ? bus.in2_valid : bus.in1_valid;
    assign in_data_s     = io_s ? bus.in2_data  : bus.in1_data;
    assign in_blocked_s  = (a_op_s == A_IN) && !sel_valid_s;
    assign out_blocked_s = o_s && out_valid_r && !bus.out_ready;
    // Reset is folded in so nothing is readied or committed while rst is high
    assign commit_s      = !rst && !in_blocked_s && !out_blocked_s;

    assign c_dec_s  = c_r - DATA_W'(1);
    assign pc_inc_s = pc_r + PC_W'(1);

    hovalaag_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (alu_op_s),
        .a     (a_r),
        .b     (b_r),
        .c     (c_r),
        .f     (f_r),
        .m     (alu_m_s),
        .new_f (alu_new_f_s)
    );

    // Next architectural state, applied only when the instruction commits
    always_comb begin
        a_nx_s  = a_r;
        b_nx_s  = b_r;
        c_nx_s  = c_r;
        d_nx_s  = d_r;
        w_nx_s  = w_r;
        f_nx_s  = f_r;
        pc_nx_s = pc_inc_s;
        case (a_op_s)
            A_M:     a_nx_s = alu_m_s;
            A_D:     a_nx_s = d_r;
            A_IN:    a_nx_s = in_data_s;
            default: a_nx_s = a_r;
        endcase
        case (b_op_s)
            B_M:     b_nx_s = alu_m_s;
            B_A:     b_nx_s = a_r;
            B_K:     b_nx_s = k_s;
            default: b_nx_s = b_r;
        endcase
        if (d_op_s) d_nx_s = a_r;
        else        d_nx_s = d_r;
        case (w_op_s)
            W_M:     w_nx_s = alu_m_s;
            W_A:     w_nx_s = a_r;
            W_K:     w_nx_s = k_s;
            default: w_nx_s = w_r;
        endcase
        case (f_op_s)
            F_ZERO:  f_nx_s = ~|{alu_new_f_s, alu_m_s};
            F_NEWF:  f_nx_s = alu_new_f_s;
            F_NOTF:  f_nx_s = ~alu_new_f_s;
            default: f_nx_s = f_r;
        endcase
        case (c_op_s)
            C_M:            c_nx_s = alu_m_s;
            C_DEC, C_DECNZ: c_nx_s = c_dec_s;
            default:        c_nx_s = c_r;
        endcase
        // DECNZ with a non-zero result overrides the PC field
        if ((c_op_s == C_DECNZ) && (c_dec_s != '0)) begin
            pc_nx_s = l_s;
        end else begin
            case (pc_op_s)
                PC_JMP:  pc_nx_s = l_s;
                PC_JF:   pc_nx_s = f_nx_s ? l_s : pc_inc_s;
                PC_JNF:  pc_nx_s = f_nx_s ? pc_inc_s : l_s;
                default: pc_nx_s = pc_inc_s;
            endcase
        end
    end

    // Architectural registers: update on commit, hold through stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            c_r  <= '0;
            d_r  <= '0;
            w_r  <= '0;
            f_r  <= 1'b0;
            pc_r <= '0;
        end else if (commit_s) begin
            a_r  <= a_nx_s;
            b_r  <= b_nx_s;
            c_r  <= c_nx_s;
            d_r  <= d_nx_s;
            w_r  <= w_nx_s;
            f_r  <= f_nx_s;
            pc_r <= pc_nx_s;
        end
    end

    // Output holding register; captures W as it was before this instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r   <= '0;
            out_select_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else if (commit_s && o_s) begin
            out_data_r   <= w_r;
            out_select_r <= io_s;
            out_valid_r  <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign bus.in1_ready  = commit_s && (a_op_s == A_IN) && !io_s;
    assign bus.in2_ready  = commit_s && (a_op_s == A_IN) && io_s;
    assign bus.stall      = !rst && !commit_s;
    assign bus.pc         = pc_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_select = out_select_r;
    assign bus.out_valid  = out_valid_r;
endmodule

// File: doc/hovalaag_stall_core.md
# hovalaag_stall_core

Parametrised, flow-controlled successor to the Hovalaag CPU core. It keeps the 32-bit Hovalaag instruction encoding and register set (A, B, C, D, W, F, PC), with a configurable data width and program-counter width. Both input channels and the output channel use valid/ready handshakes. Whenever an instruction's I/O cannot complete, the core stalls cleanly, so it can be placed behind FIFOs or slow peripherals without external gating.

## Interface
- DATA_W, 12: datapath width; must be ≥12.
- PC_W, 8: program-counter width; must be ≥8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in1_data  in  DATA_W  channel 1 input word.
- in1_valid  in  1  in1_data is available.
- in1_ready  out  1  in1_data is consumed this cycle.
- in2_data / in2_valid / in2_ready: same as channel 1, for channel 2.
- out_data  out  DATA_W  output word.
- out_valid  out  1  out_data is pending.
- out_select  out  1  0 = OUT1, 1 = OUT2.
- out_ready  in  1  sink accepts out_data.
- instr  in  32  instruction at address pc; combinational fetch, no wait states.
- pc  out  PC_W  program counter.
- stall  out  1  the current instruction is not committing this cycle.

## Operation
Instruction fields are unchanged:
- alu[31:28], A[27:26], B[25:24], C[23:22], D[21], W[20:19], F[18:17], PC[16:15], O[14], IO[13], long-K flag [12].

Constant extension:
- K: instr[12]=1 gives instr[11:0]; instr[12]=0 gives instr[11:6]. In both forms the field is sign-extended to DATA_W.
- L: instr[12]=1 gives instr[7:0]; instr[12]=0 gives instr[5:0]. L is zero-extended to PC_W.

Commit condition:
- commit = ~need_in_blocked & ~need_out_blocked.
- need_in_blocked = (A_op==11) & ~valid of the channel selected by IO.
- need_out_blocked = O & out_valid & ~out_ready.
- stall = ~commit. During reset, stall = 0.

On commit, all units update exactly as in the Hovalaag core:
- A: hold / M / D / IN.
- B: hold / M / A / K.
- D: hold / A.
- W: hold / M / A / K.
- F: hold / zero-flag of {newF,M} / newF / ~newF.
- C: hold / M / C−1 / C−1. Decrement wraps modulo 2^DATA_W.
- PC: +1 / L / L-if-F / L-if-~F. The F tested is the F value updated by this same instruction.

DECNZ (C_op=11):
- If the decremented C ≠ 0, PC ← L, overriding PC_op.
- Otherwise PC_op applies.

PC increment wraps modulo 2^PC_W.

Input handshake:
- inN_ready = commit & (A_op==11) & (IO==N−1).
- Only the selected channel is ever readied.
- ready depends combinationally on valid. The source must not make valid depend on ready.

Output handshake:
- On commit with O=1: out_data ← W (the value before this instruction's W update), out_select ← IO, out_valid ← 1.
- Otherwise, when out_valid & out_ready: out_valid ← 0. out_data and out_select hold.
- If a pending output is accepted in the same cycle a new O instruction commits, the new word is loaded and out_valid stays 1.

During a stall, no state changes: registers, F, C, pc and the output register all hold. The exception is that out_valid may still clear through out_ready.

Reset:
- A, B, C, D, W, F, pc, out_data, out_select and out_valid all go to 0, asynchronously.
- in1_ready and in2_ready are forced to 0.
- Asserting reset mid-stall discards the stalled instruction.

## Timing
- One instruction per cycle when there are no stalls. Register results are visible the cycle after commit.
- inN_ready is combinational, in the same cycle as commit. The data is written to A at that edge.
- out_valid rises the cycle after the committing O instruction.
- Minimum output spacing is one word per cycle when out_ready is held at 1.
- stall is combinational from instr, the valid signals, out_valid and out_ready.
- After rst deasserts, the first commit is possible at the first rising edge. pc=0 is presented throughout reset.

## Structure
- Shared package hovalaag_pkg holds:
  - opcode-field localparams (A_*, B_*, C_*, W_*, F_*, PC_* encodings);
  - the field bit positions;
  - the K/L extension functions, parametrised by width.
- Sub-module hovalaag_alu, parametrised by DATA_W, implements the existing 16-op ALU:
  - inputs: op, A, B, C, F;
  - outputs: M, newF.
- The core instantiates one hovalaag_alu. All sequential logic lives in the core.

## Test plan
- **Input stall:** A←IN1 instruction at pc=0, with in1_valid=0 for 3 cycles. Required: stall=1, pc=0, in1_ready=0 throughout. Then in1_valid=1, in1_data=0x123. Required: in1_ready=1 that cycle, A=0x123 and pc=1 on the next cycle, in2_ready=0 always.
- **Output backpressure:** preload W=0x05A via W←K with long K. Issue O=1, IO=1 with out_ready=0. Required: out_valid=1, out_data=0x05A, out_select=1. Issue a second O instruction. Required: it stalls until out_ready=1, then replaces the word with no loss or duplication.
- **DECNZ wrap:** from reset, C=0, issue C_op=11 with L=5. Required: C=0xFFF, pc=5. Force C=1 and repeat. Required: C=0, pc follows PC_op=00 (pc+1).
- **Width generics:** instantiate DATA_W=16, PC_W=10.
  - B←K with short K, instr[11:6]=6'b100000. Required: B=0xFFE0.
  - B←K with long K=0x800. Required: B=0xF800.
  - pc=0x3FF with PC_op=00. Required: wraps to 0x000.
- **Async reset mid-stall:** during an output stall, with A=0x7FF and pc=0x12, pulse rst between clock edges. Required: all outputs and registers read 0 immediately, and the stalled instruction never commits.
- **F-then-branch:** a single instruction with F_op=10 and PC_op=10 branches to L exactly when the newF produced by that same instruction is 1.
